// File: rtl/demux_8_buf_pkg.sv
// demux_8_buf_pkg
// Shared constants and helpers for the buffered 1-to-8 distributor.
//   NUM_CH      number of output slots
//   ADDR_W      width of the destination address
//   dest_decode one-hot decode of a destination address
package demux_8_buf_pkg;

  localparam int NUM_CH = 8;
  localparam int ADDR_W = 3;

  // One-hot select for a single destination slot.
  function automatic logic [NUM_CH-1:0] dest_decode(input logic [ADDR_W-1:0] a);
    logic [NUM_CH-1:0] onehot_s;
    onehot_s = {{(NUM_CH-1){1'b0}}, 1'b1} << a;
    return onehot_s;
  endfunction

endpackage

// File: rtl/demux_8_buf_slot.sv
// demux_8_buf_slot
// One-entry output slot: a valid flag plus a data register.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   load        write d into the slot this edge (wins over a same-cycle drain)
//   ready       consumer takes the slot this cycle
//   d           word to load
//   valid       slot holds a word
//   q           held word (keeps its last value after draining)
//   free        slot can accept a word this cycle (empty or draining)
module demux_8_buf_slot #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             ready,
  input  logic [width-1:0] d,
  output logic             valid,
  output logic [width-1:0] q,
  output logic             free
);

  logic             valid_r;
  logic [width-1:0] q_r;

  // Slot register: load replaces (even while draining), otherwise drain clears valid only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      q_r     <= {width{1'b0}};
    end else if (load) begin
      valid_r <= 1'b1;
      q_r     <= d;
    end else if (valid_r && ready) begin
      valid_r <= 1'b0;
      q_r     <= q_r;
    end else begin
      valid_r <= valid_r;
      q_r     <= q_r;
    end
  end

  assign valid = valid_r;
  assign q     = q_r;
  assign free  = !valid_r || ready;

endmodule

// File: rtl/demux_8_buf.sv
// demux_8_buf
// Buffered 1-to-8 distributor: routes one tagged input word into one of eight
// one-entry output slots, or into all eight on broadcast.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   enable      active-low: 1 stops input acceptance, slots still drain
//   in_valid    input word present
//   in_ready    input accepted when in_valid && in_ready
//   addr        destination slot (ignored on broadcast)
//   bcast       write the word into all eight slots
//   in_data     input word
//   out_valid   bit i: slot i holds a word
//   out_ready   bit i: consumer i takes slot i this cycle
//   out_data    slot i at bits [i*width +: width]
module demux_8_buf
  import demux_8_buf_pkg::*;
#(
  parameter int width = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDR_W-1:0]       addr,
  input  logic                    bcast,
  input  logic [width-1:0]        in_data,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic [NUM_CH*width-1:0] out_data
);

  logic [NUM_CH-1:0] free_s;
  logic [NUM_CH-1:0] load_s;
  logic              in_ready_s;
  logic              accept_s;

  // Acceptance: held low in reset and while disabled; broadcast needs every slot free
  // so it never loads partially. Never depends on in_valid.
  always_comb begin
    in_ready_s = 1'b0;
    if (!rst_n) begin
      in_ready_s = 1'b0;
    end else if (enable) begin
      in_ready_s = 1'b0;
    end else if (bcast) begin
      in_ready_s = &free_s;
    end else begin
      in_ready_s = free_s[addr];
    end
  end

  assign accept_s = in_valid && in_ready_s;

  // Per-slot load strobes from the accepted word's destination.
  always_comb begin
    load_s = {NUM_CH{1'b0}};
    if (!accept_s) begin
      load_s = {NUM_CH{1'b0}};
    end else if (bcast) begin
      load_s = {NUM_CH{1'b1}};
    end else begin
      load_s = dest_decode(addr);
    end
  end

  assign in_ready = in_ready_s;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    demux_8_buf_slot #(.width(width)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load_s[i]),
      .ready (out_ready[i]),
      .d     (in_data),
      .valid (out_valid[i]),
      .q     (out_data[i*width +: width]),
      .free  (free_s[i])
    );
  end

endmodule

// File: tb/tb_demux_8_buf.sv
// tb_demux_8_buf
// Directed self-checking bench for demux_8_buf.
module tb_demux_8_buf;

  logic         clk;
  logic         rst_n;
  logic         enable;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   addr;
  logic         bcast;
  logic [31:0]  in_data;
  logic [7:0]   out_valid;
  logic [7:0]   out_ready;
  logic [255:0] out_data;

  int checks;
  int errors;

  demux_8_buf #(.width(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .addr      (addr),
    .bcast     (bcast),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; in_valid = 1'b0; addr = 3'd0; bcast = 1'b0;
    in_data = 32'h0; out_ready = 8'h00;
    #1;
    checks++;
    if (out_valid !== 8'h00) begin errors++; $display("FAIL reset_valid: got %h want 00", out_valid); end
    checks++;
    if (out_data !== 256'h0) begin errors++; $display("FAIL reset_data: got %h want 0", out_data); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    step(); step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single_route();
    in_valid = 1'b1; addr = 3'd5; in_data = 32'hDEADBEEF;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 8'h20) begin errors++; $display("FAIL single_valid: got %h want 20", out_valid); end
    checks++;
    if (out_data !== (256'hDEADBEEF << 160)) begin
      errors++; $display("FAIL single_data: got %h want slot5=deadbeef others 0", out_data);
    end
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; addr = 3'd3; in_data = 32'h11111111;
    step();
    in_data = 32'h33333333; out_ready = 8'h00;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready: got %b want 0", in_ready); end
    step();
    checks++;
    if (out_valid !== 8'h28) begin errors++; $display("FAIL bp_hold_valid: got %h want 28", out_valid); end
    checks++;
    if (out_data[96 +: 32] !== 32'h11111111) begin
      errors++; $display("FAIL bp_hold_data: got %h want 11111111", out_data[96 +: 32]);
    end
    out_ready = 8'h08;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0; out_ready = 8'h00;
    checks++;
    if (out_valid !== 8'h28) begin errors++; $display("FAIL bp_replace_valid: got %h want 28", out_valid); end
    checks++;
    if (out_data[96 +: 32] !== 32'h33333333) begin
      errors++; $display("FAIL bp_replace_data: got %h want 33333333", out_data[96 +: 32]);
    end
  endtask

  task automatic test_broadcast();
    in_valid = 1'b1; addr = 3'd6; in_data = 32'h66666666;
    step();
    bcast = 1'b1; addr = 3'd0; in_data = 32'hAAAA5555; out_ready = 8'hBF;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bcast_stall_ready: got %b want 0", in_ready); end
    step();
    checks++;
    if (out_valid !== 8'h40) begin errors++; $display("FAIL bcast_no_partial: got %h want 40", out_valid); end
    out_ready = 8'hFF;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bcast_ready: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0; bcast = 1'b0; out_ready = 8'h00;
    checks++;
    if (out_valid !== 8'hFF) begin errors++; $display("FAIL bcast_valid: got %h want ff", out_valid); end
    checks++;
    if (out_data !== {8{32'hAAAA5555}}) begin
      errors++; $display("FAIL bcast_data: got %h want all aaaa5555", out_data);
    end
  endtask

  task automatic test_enable();
    enable = 1'b1; in_valid = 1'b1; addr = 3'd2; in_data = 32'h12345678;
    for (int i = 0; i < 10; i++) begin
      out_ready = (i == 4) ? 8'h0F : 8'h00;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL enable_ready cyc%0d: got %b want 0", i, in_ready); end
      step();
    end
    out_ready = 8'h00;
    checks++;
    if (out_valid !== 8'hF0) begin errors++; $display("FAIL enable_drain_valid: got %h want f0", out_valid); end
    checks++;
    if (out_data !== {8{32'hAAAA5555}}) begin
      errors++; $display("FAIL enable_no_load: got %h want all aaaa5555", out_data);
    end
    enable = 1'b0; in_valid = 1'b0; out_ready = 8'hFF;
    step();
    out_ready = 8'h00;
    checks++;
    if (out_valid !== 8'h00) begin errors++; $display("FAIL enable_drain_all: got %h want 00", out_valid); end
  endtask

  task automatic test_streaming();
    logic [7:0] exp_v;
    out_ready = 8'hFF; in_valid = 1'b1; bcast = 1'b0;
    for (int k = 0; k < 64; k++) begin
      addr = 3'(k % 8);
      in_data = 32'hC0000000 + 32'(k);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready w%0d: got %b want 1", k, in_ready); end
      step();
      exp_v = 8'h01 << (k % 8);
      checks++;
      if (out_valid !== exp_v) begin
        errors++; $display("FAIL stream_valid w%0d: got %h want %h", k, out_valid, exp_v);
      end
      checks++;
      if (out_data[(k % 8)*32 +: 32] !== (32'hC0000000 + 32'(k))) begin
        errors++; $display("FAIL stream_data w%0d: got %h want %h", k, out_data[(k % 8)*32 +: 32],
                           32'hC0000000 + 32'(k));
      end
    end
    in_valid = 1'b0;
    step();
    out_ready = 8'h00;
    checks++;
    if (out_valid !== 8'h00) begin errors++; $display("FAIL stream_end_valid: got %h want 00", out_valid); end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; addr = 3'd1; in_data = 32'h0BADF00D;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 8'h02) begin errors++; $display("FAIL mid_pre_valid: got %h want 02", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 8'h00) begin errors++; $display("FAIL mid_reset_valid: got %h want 00", out_valid); end
    checks++;
    if (out_data !== 256'h0) begin errors++; $display("FAIL mid_reset_data: got %h want 0", out_data); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_ready: got %b want 0", in_ready); end
    step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_release_ready: got %b want 1", in_ready); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_route();
    test_backpressure();
    test_broadcast();
    test_enable();
    test_streaming();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
